// File: rtl/csa_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// csa_accumulator_pkg
// Shared definitions for the carry-select accumulator:
//   - default DATA_WIDTH / BLOCK_WIDTH / COUNT_WIDTH constants
//   - the three-state controller encoding (IDLE, ACCUM, DONE)
// ---------------------------------------------------------------------------
package csa_accumulator_pkg;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_BLOCK_WIDTH = 4;
   localparam int DEF_COUNT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage : csa_accumulator_pkg

// File: rtl/csa_accumulator_adder.sv
// ---------------------------------------------------------------------------
// carry_select_adder
// Purely combinational carry-select adder. The operands are split into
// DATA_WIDTH/BLOCK_WIDTH blocks; each block precomputes its sum for both
// possible incoming carries and the real carry picks one of them.
//
// Ports:
//   operand_a_i  DATA_WIDTH  first addend
//   operand_b_i  DATA_WIDTH  second addend
//   carry_i      1           carry into the least-significant block
//   sum_o        DATA_WIDTH  sum modulo 2^DATA_WIDTH
//   carry_o      1           carry out of the most-significant block
// ---------------------------------------------------------------------------
module carry_select_adder
   import csa_accumulator_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] operand_a_i,
   input  logic [DATA_WIDTH-1:0] operand_b_i,
   input  logic                  carry_i,
   output logic [DATA_WIDTH-1:0] sum_o,
   output logic                  carry_o
);

   localparam int NUM_BLOCKS = DATA_WIDTH / BLOCK_WIDTH;

   // A partial last block would silently drop or mis-align bits.
   if ((DATA_WIDTH % BLOCK_WIDTH) != 0) begin : g_width_check
      $error("carry_select_adder: DATA_WIDTH (%0d) must be a multiple of BLOCK_WIDTH (%0d)",
             DATA_WIDTH, BLOCK_WIDTH);
   end

   always_comb begin
      logic                 w_carry;
      logic [BLOCK_WIDTH:0] w_sum_c0;
      logic [BLOCK_WIDTH:0] w_sum_c1;
      // NOTE: every variable written here gets a value before any branch or
      // loop reads it, and the chain uses blocking '=' so each block sees the
      // carry produced by the block below it in the same evaluation; a
      // missing default would infer a latch.
      sum_o    = '0;
      w_carry  = carry_i;
      w_sum_c0 = '0;
      w_sum_c1 = '0;
      for (int b = 0; b < NUM_BLOCKS; b++) begin
         w_sum_c0 = {1'b0, operand_a_i[b*BLOCK_WIDTH +: BLOCK_WIDTH]}
                  + {1'b0, operand_b_i[b*BLOCK_WIDTH +: BLOCK_WIDTH]};
         w_sum_c1 = w_sum_c0 + (BLOCK_WIDTH+1)'(1);
         sum_o[b*BLOCK_WIDTH +: BLOCK_WIDTH] = w_carry ? w_sum_c1[BLOCK_WIDTH-1:0]
                                                       : w_sum_c0[BLOCK_WIDTH-1:0];
         w_carry = w_carry ? w_sum_c1[BLOCK_WIDTH] : w_sum_c0[BLOCK_WIDTH];
      end
      carry_o = w_carry;
   end

endmodule : carry_select_adder

// File: rtl/csa_accumulator.sv
// ---------------------------------------------------------------------------
// csa_accumulator
// Sums num_terms_i unsigned operands arriving over a valid/ready handshake,
// one per cycle at most, using a single combinational carry-select adder
// feeding the accumulator register. Reports the sum modulo 2^DATA_WIDTH and
// a sticky overflow flag, held until the downstream consumer takes it.
//
// Ports:
//   clk_i            1            clock, rising edge
//   rst_n_i          1            synchronous active-low reset
//   start_i          1            begin accumulation (IDLE only)
//   num_terms_i      COUNT_WIDTH  number of operands, sampled with start_i
//   operand_i        DATA_WIDTH   unsigned operand
//   operand_valid_i  1            operand_i is valid
//   operand_ready_o  1            operand accepted this cycle (state==ACCUM)
//   result_o         DATA_WIDTH   accumulated sum
//   overflow_o       1            sticky carry-out flag
//   result_valid_o   1            result is final (state==DONE)
//   result_ready_i   1            downstream consumes the result
//   busy_o           1            state is not IDLE
// ---------------------------------------------------------------------------
module csa_accumulator
   import csa_accumulator_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
   parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   start_i,
   input  logic [COUNT_WIDTH-1:0] num_terms_i,
   input  logic [DATA_WIDTH-1:0]  operand_i,
   input  logic                   operand_valid_i,
   output logic                   operand_ready_o,
   output logic [DATA_WIDTH-1:0]  result_o,
   output logic                   overflow_o,
   output logic                   result_valid_o,
   input  logic                   result_ready_i,
   output logic                   busy_o
);

   state_t                 r_state;
   state_t                 w_state_next;
   logic [DATA_WIDTH-1:0]  r_acc;
   logic [COUNT_WIDTH-1:0] r_count;
   logic                   r_overflow;

   logic [DATA_WIDTH-1:0]  w_sum;
   logic                   w_carry;
   logic                   w_handshake;
   logic                   w_start;
   logic                   w_last_term;

   carry_select_adder #(
      .DATA_WIDTH  (DATA_WIDTH),
      .BLOCK_WIDTH (BLOCK_WIDTH)
   ) u_adder (
      .operand_a_i (r_acc),
      .operand_b_i (operand_i),
      .carry_i     (1'b0),
      .sum_o       (w_sum),
      .carry_o     (w_carry)
   );

   assign operand_ready_o = (r_state == ST_ACCUM);
   assign result_valid_o  = (r_state == ST_DONE);
   assign busy_o          = (r_state != ST_IDLE);
   assign result_o        = r_acc;
   assign overflow_o      = r_overflow;

   assign w_start     = (r_state == ST_IDLE) && start_i;
   assign w_handshake = operand_valid_i && operand_ready_o;
   assign w_last_term = (r_count == COUNT_WIDTH'(1));

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_state_next = (num_terms_i == '0) ? ST_DONE : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (w_handshake && w_last_term) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (result_ready_i) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking '<=' so every register samples
   // the pre-edge values of the others, matching the hardware.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_IDLE;
         r_acc      <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_start) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_count    <= num_terms_i;
         end else if (w_handshake) begin
            r_acc      <= w_sum;
            r_overflow <= r_overflow | w_carry;
            r_count    <= r_count - COUNT_WIDTH'(1);
         end
      end
   end

endmodule : csa_accumulator

// File: tb/tb_csa_accumulator.sv
// ---------------------------------------------------------------------------
// tb_csa_accumulator
// Self-checking bench for csa_accumulator: a table of directed transactions,
// hand-written reset/abort sequences, and randomized transactions checked
// against a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_csa_accumulator;

   localparam int DW = 32;
   localparam int BW = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [CW-1:0] num_terms;
   logic [DW-1:0] operand;
   logic          operand_valid;
   logic          operand_ready;
   logic [DW-1:0] result;
   logic          overflow;
   logic          result_valid;
   logic          result_ready;
   logic          busy;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      int              n;
      logic [15:0][31:0] ops;
      logic [31:0]     exp_res;
      logic            exp_ovf;
      int              gap_max;
      int              done_wait;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   csa_accumulator #(
      .DATA_WIDTH  (DW),
      .BLOCK_WIDTH (BW),
      .COUNT_WIDTH (CW)
   ) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .start_i         (start),
      .num_terms_i     (num_terms),
      .operand_i       (operand),
      .operand_valid_i (operand_valid),
      .operand_ready_o (operand_ready),
      .result_o        (result),
      .overflow_o      (overflow),
      .result_valid_o  (result_valid),
      .result_ready_i  (result_ready),
      .busy_o          (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the true (unbounded) sum of the terms; the reported result is
   // its low DW bits and overflow is set iff the true sum ever reached 2^DW.
   function automatic void model(input int n, input logic [15:0][31:0] ops,
                                 output logic [31:0] res, output logic ovf);
      logic [63:0] total;
      total = '0;
      for (int i = 0; i < n; i++) total += {32'd0, ops[i]};
      res = total[31:0];
      ovf = (total[63:32] != 32'd0);
   endfunction

   function automatic vec_t mk(input int n, input logic [31:0] o0, input logic [31:0] o1,
                               input logic [31:0] o2, input logic [31:0] o3,
                               input logic [31:0] res, input logic ovf,
                               input int gap_max, input int done_wait);
      vec_t v;
      v.ops     = '0;
      v.n       = n;
      v.ops[0]  = o0;
      v.ops[1]  = o1;
      v.ops[2]  = o2;
      v.ops[3]  = o3;
      v.exp_res = res;
      v.exp_ovf = ovf;
      v.gap_max = gap_max;
      v.done_wait = done_wait;
      return v;
   endfunction

   // One full transaction from IDLE back to IDLE.
   task automatic run_txn(input string tag, input int n, input logic [15:0][31:0] ops,
                          input int gap_max, input int done_wait,
                          input logic [31:0] exp_res, input logic exp_ovf);
      logic [63:0] partial;
      int          gaps;
      partial = '0;

      check({tag, "/idle_ready"}, 64'(operand_ready), 64'd0);
      check({tag, "/idle_busy"},  64'(busy), 64'd0);

      start     = 1'b1;
      num_terms = n[CW-1:0];
      tick();
      start     = 1'b0;
      num_terms = '0;
      check({tag, "/busy"}, 64'(busy), 64'd1);

      if (n == 0) begin
         check({tag, "/zero_valid"}, 64'(result_valid), 64'd1);
         check({tag, "/zero_ready"}, 64'(operand_ready), 64'd0);
      end else begin
         check({tag, "/accum_ready"}, 64'(operand_ready), 64'd1);
         check({tag, "/cleared"}, 64'(result), 64'd0);
         for (int i = 0; i < n; i++) begin
            gaps = int'($urandom_range(gap_max, 0));
            for (int g = 0; g < gaps; g++) begin
               operand_valid = 1'b0;
               operand       = $urandom;
               tick();
               check({tag, "/gap_hold"},  64'(result), 64'(partial[31:0]));
               check({tag, "/gap_valid"}, 64'(result_valid), 64'd0);
            end
            operand_valid = 1'b1;
            operand       = ops[i];
            tick();
            operand_valid = 1'b0;
            partial      += {32'd0, ops[i]};
            if (i < n - 1) begin
               check({tag, "/partial"}, 64'(result), 64'(partial[31:0]));
               check({tag, "/early_valid"}, 64'(result_valid), 64'd0);
            end
         end
         check({tag, "/valid_latency"}, 64'(result_valid), 64'd1);
         check({tag, "/done_ready"}, 64'(operand_ready), 64'd0);
      end

      check({tag, "/result"},   64'(result), 64'(exp_res));
      check({tag, "/overflow"}, 64'(overflow), 64'(exp_ovf));

      // Hold the result un-consumed; a start pulse here must be ignored.
      for (int w = 0; w < done_wait; w++) begin
         result_ready = 1'b0;
         start        = (w == 1);
         num_terms    = 8'd3;
         tick();
         start        = 1'b0;
         check({tag, "/hold_valid"}, 64'(result_valid), 64'd1);
         check({tag, "/hold_result"}, 64'(result), 64'(exp_res));
         check({tag, "/hold_ovf"}, 64'(overflow), 64'(exp_ovf));
      end
      num_terms = '0;

      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      check({tag, "/back_idle"}, 64'(busy), 64'd0);
      check({tag, "/valid_drop"}, 64'(result_valid), 64'd0);
      check({tag, "/kept_result"}, 64'(result), 64'(exp_res));
      check({tag, "/kept_ovf"}, 64'(overflow), 64'(exp_ovf));
   endtask

   initial begin
      logic [15:0][31:0] ops;
      logic [31:0]       m_res;
      logic              m_ovf;
      int                n;

      rst_n         = 1'b0;
      start         = 1'b0;
      num_terms     = '0;
      operand       = '0;
      operand_valid = 1'b0;
      result_ready  = 1'b0;

      vecs[0] = mk(3, 32'd5, 32'd7, 32'd9, 32'd0, 32'd21, 1'b0, 0, 0);
      vecs[1] = mk(2, 32'hFFFF_FFFF, 32'h2, 32'd0, 32'd0, 32'h1, 1'b1, 0, 0);
      vecs[2] = mk(0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0, 0);
      vecs[3] = mk(4, 32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 1'b0, 3, 0);
      vecs[4] = mk(3, 32'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1, 5);
      vecs[5] = mk(4, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                   32'd0, 1'b1, 2, 0);
      vecs[6] = mk(1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 0, 0);
      vecs[7] = mk(2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1, 1, 1);

      // Reset state.
      tick();
      tick();
      check("rst/result", 64'(result), 64'd0);
      check("rst/overflow", 64'(overflow), 64'd0);
      check("rst/valid", 64'(result_valid), 64'd0);
      check("rst/ready", 64'(operand_ready), 64'd0);
      check("rst/busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      tick();

      // Directed table.
      for (int v = 0; v < 8; v++) begin
         run_txn($sformatf("vec%0d", v), vecs[v].n, vecs[v].ops, vecs[v].gap_max,
                 vecs[v].done_wait, vecs[v].exp_res, vecs[v].exp_ovf);
      end

      // Reset in the middle of a 4-term accumulation, after 2 terms.
      start     = 1'b1;
      num_terms = 8'd4;
      tick();
      start     = 1'b0;
      operand_valid = 1'b1;
      operand   = 32'd10;
      tick();
      operand   = 32'd20;
      tick();
      check("abort/partial", 64'(result), 64'd30);
      operand   = 32'd40;
      rst_n     = 1'b0;
      start     = 1'b1;
      result_ready = 1'b1;
      tick();
      check("abort/result", 64'(result), 64'd0);
      check("abort/overflow", 64'(overflow), 64'd0);
      check("abort/valid", 64'(result_valid), 64'd0);
      check("abort/ready", 64'(operand_ready), 64'd0);
      check("abort/busy", 64'(busy), 64'd0);
      rst_n         = 1'b1;
      start         = 1'b0;
      result_ready  = 1'b0;
      operand_valid = 1'b0;
      tick();
      check("abort/stay_idle", 64'(busy), 64'd0);
      ops = '0;
      ops[0] = 32'd1;
      ops[1] = 32'd1;
      run_txn("after_abort", 2, ops, 0, 0, 32'd2, 1'b0);

      // Randomized transactions against the reference model.
      for (int t = 0; t < 25; t++) begin
         n   = int'($urandom_range(12, 0));
         ops = '0;
         for (int i = 0; i < 16; i++) begin
            if ($urandom_range(1, 0) == 1) ops[i] = 32'hC000_0000 | $urandom;
            else                          ops[i] = $urandom_range(5000, 0);
         end
         model(n, ops, m_res, m_ovf);
         run_txn($sformatf("rand%0d", t), n, ops, 3, int'($urandom_range(2, 0)), m_res, m_ovf);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_csa_accumulator
